// File: rtl/lfsr_seq_ctrl_if.sv
// Job handshake and result bus for lfsr_seq_ctrl.
// The abort input exists only when LFSR_SEQ_CTRL_ABORT_EN is defined.
interface lfsr_seq_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic [3:0]       seed;
  logic [CNT_W-1:0] num_steps;
  logic             mode;
`ifdef LFSR_SEQ_CTRL_ABORT_EN
  logic             abort;
`endif
  logic             busy;
  logic [3:0]       state_out;
  logic             out_valid;
  logic [CNT_W-1:0] count;
  logic             done;
  logic             err;

  modport master (
    output start, seed, num_steps, mode,
`ifdef LFSR_SEQ_CTRL_ABORT_EN
    output abort,
`endif
    input  busy, state_out, out_valid, count, done, err
  );

  modport slave (
    input  start, seed, num_steps, mode,
`ifdef LFSR_SEQ_CTRL_ABORT_EN
    input  abort,
`endif
    output busy, state_out, out_valid, count, done, err
  );
endinterface

// File: rtl/lfsr_seq_ctrl.sv
// Job sequencer around a 4-bit Fibonacci LFSR: fixed-count or period-measurement runs.
// Define LFSR_SEQ_CTRL_ABORT_EN to add the abort input on the bus.
module lfsr_seq_ctrl #(
  parameter int CNT_W = 8
) (
  input logic           clk,
  input logic           rst,
  lfsr_seq_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, DONE, ERR} state_t;

  state_t           fsm;
  logic [3:0]       seed_q;
  logic [CNT_W-1:0] steps_q;
  logic             mode_q;
  logic [3:0]       lfsr;
  logic [CNT_W-1:0] cnt;
  logic             busy_r;
  logic             valid_r;
  logic             done_r;
  logic             err_r;

  logic [3:0]       lfsr_nxt;
  logic [CNT_W-1:0] cnt_inc;
  logic             cnt_full;
  logic             finish;
  logic             abort_req;

  always_comb begin
    lfsr_nxt = {lfsr[1] ^ lfsr[0], lfsr[3:1]};
    cnt_inc  = cnt + CNT_W'(1);
    cnt_full = (cnt == '1);
    // Exit is judged on the post-step values so the final step is still taken.
    finish   = mode_q ? (lfsr_nxt == seed_q) : (cnt_inc == steps_q);
`ifdef LFSR_SEQ_CTRL_ABORT_EN
    abort_req = bus.abort;
`else
    abort_req = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fsm     <= IDLE;
      seed_q  <= '0;
      steps_q <= '0;
      mode_q  <= 1'b0;
      lfsr    <= '0;
      cnt     <= '0;
      busy_r  <= 1'b0;
      valid_r <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
      case (fsm)
        IDLE: begin
          busy_r <= 1'b0;
          if (bus.start) begin
            seed_q  <= bus.seed;
            steps_q <= bus.num_steps;
            mode_q  <= bus.mode;
            cnt     <= '0;
            busy_r  <= 1'b1;
            fsm     <= LOAD;
          end
        end
        LOAD: begin
          if (abort_req) begin
            busy_r <= 1'b0;
            fsm    <= IDLE;
          end else begin
            lfsr   <= seed_q;
            busy_r <= 1'b1;
            if (seed_q == 4'd0)
              fsm <= ERR;
            else if (!mode_q && steps_q == '0)
              fsm <= DONE;
            else
              fsm <= RUN;
          end
        end
        RUN: begin
          if (abort_req) begin
            busy_r <= 1'b0;
            fsm    <= IDLE;
          end else if (cnt_full) begin
            // Counter saturated: refuse the step rather than wrap.
            fsm <= ERR;
          end else begin
            lfsr    <= lfsr_nxt;
            cnt     <= cnt_inc;
            valid_r <= 1'b1;
            if (finish)
              fsm <= DONE;
          end
        end
        DONE: begin
          done_r <= 1'b1;
          busy_r <= 1'b1;
          fsm    <= IDLE;
        end
        ERR: begin
          err_r  <= 1'b1;
          busy_r <= 1'b1;
          fsm    <= IDLE;
        end
        default: fsm <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_r;
  assign bus.state_out = lfsr;
  assign bus.out_valid = valid_r;
  assign bus.count     = cnt;
  assign bus.done      = done_r;
  assign bus.err       = err_r;

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Bench for lfsr_seq_ctrl: job-level expected timeline model plus directed literal checks.
module tb_lfsr_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  lfsr_seq_ctrl_if #(.CNT_W(8)) a8 ();
  lfsr_seq_ctrl_if #(.CNT_W(3)) a3 ();

  lfsr_seq_ctrl #(.CNT_W(8)) dut8 (.clk(clk), .rst(rst), .bus(a8.slave));
  lfsr_seq_ctrl #(.CNT_W(3)) dut3 (.clk(clk), .rst(rst), .bus(a3.slave));

  logic ab8;
`ifdef LFSR_SEQ_CTRL_ABORT_EN
  assign ab8 = a8.abort;
`else
  assign ab8 = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  // One entry per clock edge after a job is accepted; ab marks edges taken in LOAD/RUN.
  typedef struct packed {
    logic       ab;
    logic       busy;
    logic       valid;
    logic       done;
    logic       err;
    logic [3:0] st;
    logic [7:0] cnt;
  } ent_t;
  typedef ent_t ent_q_t[$];

  function automatic logic [3:0] lfsr_next(input logic [3:0] w);
    return {w[1] ^ w[0], w[3], w[2], w[1]};
  endfunction

  function automatic ent_q_t expect_job(input logic [3:0] s, input logic [7:0] n,
                                        input logic m, input int maxc, input logic [3:0] prev);
    ent_q_t r;
    ent_t e;
    int c;
    logic [3:0] w;
    e = '{ab: 1'b0, busy: 1'b1, valid: 1'b0, done: 1'b0, err: 1'b0, st: prev, cnt: 8'd0};
    r.push_back(e);
    e.ab = 1'b1; e.st = s;
    r.push_back(e);
    if (s == 4'd0) begin
      e.ab = 1'b0; e.err = 1'b1; r.push_back(e);
    end else if (!m && n == 8'd0) begin
      e.ab = 1'b0; e.done = 1'b1; r.push_back(e);
    end else begin
      w = s;
      c = 0;
      while (1) begin
        if (c == maxc) begin
          e.ab = 1'b1; e.valid = 1'b0; r.push_back(e);
          e.ab = 1'b0; e.err = 1'b1; r.push_back(e);
          break;
        end
        w = lfsr_next(w);
        c++;
        e.ab = 1'b1; e.valid = 1'b1; e.st = w; e.cnt = 8'(c);
        r.push_back(e);
        if ((!m && c == int'(n)) || (m && w == s)) begin
          e.ab = 1'b0; e.valid = 1'b0; e.done = 1'b1; r.push_back(e);
          break;
        end
      end
    end
    e.ab = 1'b0; e.busy = 1'b0; e.valid = 1'b0; e.done = 1'b0; e.err = 1'b0;
    r.push_back(e);
    return r;
  endfunction

  ent_q_t q8, q3;
  ent_t   e8, e3;
  logic   known = 1'b0;

  always @(posedge clk) if (!rst) known <= 1'b1;

  always @(posedge clk) begin
    if (!rst) begin
      q8.delete();
      e8 <= '0;
    end else if (ab8 && q8.size() > 0 && q8[0].ab) begin
      q8.delete();
      e8 <= '{ab: 1'b0, busy: 1'b0, valid: 1'b0, done: 1'b0, err: 1'b0, st: e8.st, cnt: e8.cnt};
    end else if (q8.size() <= 1 && a8.start) begin
      q8 = expect_job(a8.seed, a8.num_steps, a8.mode, 255, e8.st);
      e8 <= q8.pop_front();
    end else if (q8.size() > 0) begin
      e8 <= q8.pop_front();
    end else begin
      e8 <= '{ab: 1'b0, busy: 1'b0, valid: 1'b0, done: 1'b0, err: 1'b0, st: e8.st, cnt: e8.cnt};
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      q3.delete();
      e3 <= '0;
    end else if (q3.size() <= 1 && a3.start) begin
      q3 = expect_job(a3.seed, {5'd0, a3.num_steps}, a3.mode, 7, e3.st);
      e3 <= q3.pop_front();
    end else if (q3.size() > 0) begin
      e3 <= q3.pop_front();
    end else begin
      e3 <= '{ab: 1'b0, busy: 1'b0, valid: 1'b0, done: 1'b0, err: 1'b0, st: e3.st, cnt: e3.cnt};
    end
  end

  always @(negedge clk) begin
    if (known) begin
      total++;
      if ({a8.busy, a8.out_valid, a8.done, a8.err, a8.state_out, a8.count} !==
          {e8.busy, e8.valid, e8.done, e8.err, e8.st, e8.cnt}) begin
        bad++;
        $display("FAIL model8 t=%0t got busy/vld/done/err/st/cnt=%b%b%b%b/%h/%0d required %b%b%b%b/%h/%0d",
                 $time, a8.busy, a8.out_valid, a8.done, a8.err, a8.state_out, a8.count,
                 e8.busy, e8.valid, e8.done, e8.err, e8.st, e8.cnt);
      end
      total++;
      if ({a3.busy, a3.out_valid, a3.done, a3.err, a3.state_out, a3.count} !==
          {e3.busy, e3.valid, e3.done, e3.err, e3.st, e3.cnt[2:0]}) begin
        bad++;
        $display("FAIL model3 t=%0t got busy/vld/done/err/st/cnt=%b%b%b%b/%h/%0d required %b%b%b%b/%h/%0d",
                 $time, a3.busy, a3.out_valid, a3.done, a3.err, a3.state_out, a3.count,
                 e3.busy, e3.valid, e3.done, e3.err, e3.st, e3.cnt[2:0]);
      end
    end
  end

  logic [3:0] vq8[$];
  logic [3:0] vq3[$];
  always @(negedge clk) begin
    if (a8.out_valid) vq8.push_back(a8.state_out);
    if (a3.out_valid) vq3.push_back(a3.state_out);
  end

  task automatic chk(input string name, input int got, input int req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end
  endtask

  // lat = edges after the accepting edge at which done/err is first visible.
  task automatic job8(input logic [3:0] s, input logic [7:0] n, input logic m,
                      output int lat, output logic gd, output logic ge);
    vq8.delete();
    a8.seed = s; a8.num_steps = n; a8.mode = m; a8.start = 1'b1;
    @(posedge clk);
    #1 a8.start = 1'b0;
    lat = -1; gd = 1'b0; ge = 1'b0;
    while (lat < 40 && !gd && !ge) begin
      @(negedge clk);
      lat++;
      gd = a8.done;
      ge = a8.err;
    end
  endtask

  task automatic job3(input logic [3:0] s, input logic [2:0] n, input logic m,
                      output int lat, output logic gd, output logic ge);
    vq3.delete();
    a3.seed = s; a3.num_steps = n; a3.mode = m; a3.start = 1'b1;
    @(posedge clk);
    #1 a3.start = 1'b0;
    lat = -1; gd = 1'b0; ge = 1'b0;
    while (lat < 40 && !gd && !ge) begin
      @(negedge clk);
      lat++;
      gd = a3.done;
      ge = a3.err;
    end
  endtask

  task automatic wait_valids8(input int want, output int seen);
    seen = 0;
    for (int i = 0; i < 30 && seen < want; i++) begin
      @(negedge clk);
      if (a8.out_valid) seen++;
    end
  endtask

  initial begin
    int lat;
    int seen;
    logic gd, ge;
    a8.start = 1'b0; a8.seed = '0; a8.num_steps = '0; a8.mode = 1'b0;
    a3.start = 1'b0; a3.seed = '0; a3.num_steps = '0; a3.mode = 1'b0;
`ifdef LFSR_SEQ_CTRL_ABORT_EN
    a8.abort = 1'b0;
    a3.abort = 1'b0;
`endif
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", int'(a8.busy), 0);
    chk("rst_state", int'(a8.state_out), 0);
    chk("rst_count", int'(a8.count), 0);
    rst = 1'b1;
    @(negedge clk);

    job8(4'b1000, 8'd3, 1'b0, lat, gd, ge);
    chk("m0_done", int'(gd), 1);
    chk("m0_lat", lat, 5);
    chk("m0_nvalid", vq8.size(), 3);
    chk("m0_v0", vq8.size() > 0 ? int'(vq8[0]) : 99, 4'b0100);
    chk("m0_v1", vq8.size() > 1 ? int'(vq8[1]) : 99, 4'b0010);
    chk("m0_v2", vq8.size() > 2 ? int'(vq8[2]) : 99, 4'b1001);
    chk("m0_count", int'(a8.count), 3);

    job8(4'b1000, 8'd0, 1'b1, lat, gd, ge);
    chk("m1_done", int'(gd), 1);
    chk("m1_lat", lat, 17);
    chk("m1_nvalid", vq8.size(), 15);
    chk("m1_v13", vq8.size() > 13 ? int'(vq8[13]) : 99, 4'b0001);
    chk("m1_v14", vq8.size() > 14 ? int'(vq8[14]) : 99, 4'b1000);
    chk("m1_state", int'(a8.state_out), 4'b1000);
    chk("m1_count", int'(a8.count), 15);

    job8(4'b0000, 8'd5, 1'b0, lat, gd, ge);
    chk("z0_err", int'(ge), 1);
    chk("z0_done", int'(gd), 0);
    chk("z0_lat", lat, 2);
    chk("z0_nvalid", vq8.size(), 0);

    job8(4'b0000, 8'd0, 1'b1, lat, gd, ge);
    chk("z1_err", int'(ge), 1);
    chk("z1_lat", lat, 2);
    chk("z1_nvalid", vq8.size(), 0);

    job8(4'b0101, 8'd0, 1'b0, lat, gd, ge);
    chk("n0_done", int'(gd), 1);
    chk("n0_lat", lat, 2);
    chk("n0_count", int'(a8.count), 0);
    chk("n0_state", int'(a8.state_out), 4'b0101);
    chk("n0_nvalid", vq8.size(), 0);

    job3(4'b1000, 3'd0, 1'b1, lat, gd, ge);
    chk("ov_err", int'(ge), 1);
    chk("ov_done", int'(gd), 0);
    chk("ov_lat", lat, 10);
    chk("ov_count", int'(a3.count), 7);
    chk("ov_state", int'(a3.state_out), 4'b0101);
    chk("ov_nvalid", vq3.size(), 7);
    job3(4'b1000, 3'd2, 1'b0, lat, gd, ge);
    chk("ov_next_done", int'(gd), 1);
    chk("ov_next_lat", lat, 4);
    chk("ov_next_count", int'(a3.count), 2);

    // Reset in the middle of a period run, with start held high throughout.
    a8.seed = 4'b1000; a8.mode = 1'b1; a8.start = 1'b1;
    @(posedge clk);
    #1 a8.start = 1'b0;
    wait_valids8(5, seen);
    chk("rr_steps", seen, 5);
    rst = 1'b0;
    a8.start = 1'b1;
    @(negedge clk);
    chk("rr_outs", int'({a8.busy, a8.out_valid, a8.done, a8.err, a8.state_out, a8.count}), 0);
    repeat (2) @(negedge clk);
    chk("rr_busy_held", int'(a8.busy), 0);
    a8.start = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rr_idle", int'(a8.busy), 0);

`ifdef LFSR_SEQ_CTRL_ABORT_EN
    a8.seed = 4'b1000; a8.mode = 1'b1; a8.start = 1'b1;
    @(posedge clk);
    #1 a8.start = 1'b0;
    wait_valids8(2, seen);
    chk("ab_steps", seen, 2);
    a8.abort = 1'b1;
    @(posedge clk);
    #1 a8.abort = 1'b0;
    @(negedge clk);
    chk("ab_busy", int'(a8.busy), 0);
    chk("ab_count", int'(a8.count), 2);
    chk("ab_state", int'(a8.state_out), 4'b0010);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("ab_no_pulse", int'(a8.done | a8.err | a8.out_valid), 0);
    end
`endif

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
